// File: rtl/tag_read_if.sv
// Tag-read bus: AR-style lookup requests, R-channel responses
// and the refill/writeback tag-update strobe.
interface tag_read_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [71:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        upd_valid;
  logic [63:0] upd_addr;
  logic        upd_dirty;
  logic        upd_inval;

  modport master (
    output araddr, arvalid, rready,
    output upd_valid, upd_addr, upd_dirty, upd_inval,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  upd_valid, upd_addr, upd_dirty, upd_inval,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/tag_read_responder.sv
// Direct-mapped tag store answering lookups in order on an R channel.
// Define TAG_PARITY_EN to store even parity per entry, returned in rdata[69].
module tag_read_responder #(
  parameter int TAG_BIT_SIZE = 8,
  parameter int RD_LATENCY   = 2,
  parameter int RESP_DEPTH   = 4
) (
  input logic       clk,
  input logic       rst_n,
  tag_read_if.slave bus
);
  localparam int SETS = 1 << TAG_BIT_SIZE;
  localparam int TW   = 64 - TAG_BIT_SIZE;
  localparam int PW   = $clog2(RESP_DEPTH);
  localparam int CW   = $clog2(RESP_DEPTH + 1);

  typedef logic [TAG_BIT_SIZE-1:0] idx_t;
  typedef logic [TW-1:0]           tag_t;

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  tag_t            tag_q [SETS];

  idx_t        ridx;
  idx_t        uidx;
  logic        hit;
  logic        nv, nd;
  tag_t        nt;
  logic        ev, ed, ep;
  tag_t        et;
  logic        accept;
  logic        pop;
  logic        push;
  logic [71:0] acc_word;
  logic [71:0] push_data;
  logic        unused_addr;

  assign ridx   = bus.araddr[TAG_BIT_SIZE-1:0];
  assign uidx   = bus.upd_addr[TAG_BIT_SIZE-1:0];
  assign accept = bus.arvalid && bus.arready;
  assign pop    = bus.rvalid && bus.rready;

  // Lookup tag bits are never compared here; the comparator does that.
  assign unused_addr = ^bus.araddr[63:TAG_BIT_SIZE];

  always_comb begin
    nv = !bus.upd_inval;
    nd = bus.upd_dirty && !bus.upd_inval;
    nt = bus.upd_inval ? tag_q[uidx]
                       : bus.upd_addr[63:TAG_BIT_SIZE];
  end

  // Same-cycle update to the looked-up set wins (write-first).
  assign hit = bus.upd_valid && (uidx == ridx);
  assign ev  = hit ? nv : valid_q[ridx];
  assign ed  = hit ? nd : dirty_q[ridx];
  assign et  = hit ? nt : tag_q[ridx];

`ifdef TAG_PARITY_EN
  logic [SETS-1:0] par_q;
  logic            np;

  assign np = ^{nv, nd, nt};
  assign ep = hit ? np : par_q[ridx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (bus.upd_valid) begin
      par_q[uidx] <= np;
    end
  end
`else
  assign ep = 1'b0;
`endif

  assign acc_word = {ev, ed, ep, 5'b0, et, ridx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= '0;
      end
    end else if (bus.upd_valid) begin
      valid_q[uidx] <= nv;
      dirty_q[uidx] <= nd;
      tag_q[uidx]   <= nt;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_nopipe
      assign push      = accept;
      assign push_data = acc_word;
    end else begin : g_pipe
      localparam int S = RD_LATENCY - 1;
      logic [S-1:0] vld;
      logic [71:0]  dat [S];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          for (int i = 0; i < S; i++) begin
            dat[i] <= '0;
          end
        end else begin
          vld[0] <= accept;
          dat[0] <= acc_word;
          for (int i = 1; i < S; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign push      = vld[S-1];
      assign push_data = dat[S-1];
    end
  endgenerate

  logic [71:0]   mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] cred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      cred   <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fcnt <= fcnt + CW'(1);
      end else if (!push && pop) begin
        fcnt <= fcnt - CW'(1);
      end
      if (accept && !pop) begin
        cred <= cred + CW'(1);
      end else if (!accept && pop) begin
        cred <= cred - CW'(1);
      end
    end
  end

  // Credits cover every word in flight, so the FIFO can never overflow.
  assign bus.arready = (cred < CW'(RESP_DEPTH));
  assign bus.rvalid  = (fcnt != '0);
  assign bus.rdata   = bus.rvalid ? mem[rd_ptr] : '0;
endmodule
